// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, one-hot ALU control words and FSM encodings for alu_sequencer
//
// Purpose: shared constants and decode helpers for the ALU sequencer slice.
//   OP_*      4-bit request opcodes (0..10 legal, 11..15 illegal)
//   CTL_*     one-hot ALU control words, bit order
//             {B15to0,AandB,AorB,notB,shlB,shrB,AaddB,AsubB,AmulB,AcmpB}
//   ST_*      sequencer state encodings
//   op2ctl    opcode -> control word, 0 for illegal opcodes
//   op_sets_carry  opcodes whose ALU carry-out updates the carry flag

package alu_seq_pkg;

  localparam logic [3:0] OP_PASSB = 4'd0;
  localparam logic [3:0] OP_AND   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_NOTB  = 4'd3;
  localparam logic [3:0] OP_SHL   = 4'd4;
  localparam logic [3:0] OP_SHR   = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;
  localparam logic [3:0] OP_SUB   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_CMP   = 4'd9;
  localparam logic [3:0] OP_ADC   = 4'd10;

  localparam logic [9:0] CTL_B15TO0 = 10'b10_0000_0000;
  localparam logic [9:0] CTL_AANDB  = 10'b01_0000_0000;
  localparam logic [9:0] CTL_AORB   = 10'b00_1000_0000;
  localparam logic [9:0] CTL_NOTB   = 10'b00_0100_0000;
  localparam logic [9:0] CTL_SHLB   = 10'b00_0010_0000;
  localparam logic [9:0] CTL_SHRB   = 10'b00_0001_0000;
  localparam logic [9:0] CTL_AADDB  = 10'b00_0000_1000;
  localparam logic [9:0] CTL_ASUBB  = 10'b00_0000_0100;
  localparam logic [9:0] CTL_AMULB  = 10'b00_0000_0010;
  localparam logic [9:0] CTL_ACMPB  = 10'b00_0000_0001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // ADC has no ALU line of its own: it uses the adder with alu_cin driven
  // from the carry flag. A zero word therefore uniquely marks an illegal op.
  function automatic logic [9:0] op2ctl(input logic [3:0] op);
    logic [9:0] ctl;
    case (op)
      OP_PASSB: ctl = CTL_B15TO0;
      OP_AND:   ctl = CTL_AANDB;
      OP_OR:    ctl = CTL_AORB;
      OP_NOTB:  ctl = CTL_NOTB;
      OP_SHL:   ctl = CTL_SHLB;
      OP_SHR:   ctl = CTL_SHRB;
      OP_ADD:   ctl = CTL_AADDB;
      OP_SUB:   ctl = CTL_ASUBB;
      OP_MUL:   ctl = CTL_AMULB;
      OP_CMP:   ctl = CTL_ACMPB;
      OP_ADC:   ctl = CTL_AADDB;
      default:  ctl = 10'b0;
    endcase
    return ctl;
  endfunction

  function automatic logic op_sets_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - two-way round-robin arbiter for the ALU sequencer
//
// Purpose: picks one of two requesters; on a tie the requester named by prio
//   wins, and every accepted grant hands priority to the other requester.
// Ports:
//   clk     in   1  clock, rising edge
//   rst     in   1  synchronous active-high reset (prio -> 0)
//   valid   in   2  {req1_valid, req0_valid}
//   accept  in   1  the current grant is being taken this cycle
//   grant   out  2  one-hot (or zero) grant, combinational
//   prio    out  1  requester that wins the next tie

module alu_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       prio
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = prio ? 2'b10 : 2'b01;
    end
  end

  // grant[1] is the winner's id, so the loser gets priority next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (accept) begin
      prio <= ~grant[1];
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - shares one combinational 16-bit ALU between two requesters
//
// Purpose: arbitrates two valid/ready requesters round-robin, registers the
//   operands and one-hot control word towards the ALU, holds MUL for
//   MUL_CYCLES cycles, and returns result/zero/carry/id on a valid/ready
//   response channel. Illegal opcodes are answered with resp_err=1.
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   reqN_valid/ready          request handshake, N = 0/1; ready is combinational
//   reqN_op/a/b               opcode and operands, held stable until ready
//   resp_valid/ready          response handshake
//   resp_id/data/z/c/err      requester id, captured ALU result and flags, illegal-op flag
//   alu_a/alu_b/alu_ctl/alu_cin   registered drive into the ALU
//   alu_out/alu_cout/alu_zout     combinational ALU results
//   busy                      sequencer is not idle

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_z,
  output logic             resp_c,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [9:0]       alu_ctl,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_zout,
  output logic             busy
);

  // cnt counts remaining EXEC cycles minus one; MUL loads MUL_CYCLES-1.
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MUL = CW'(MUL_CYCLES - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             id_q;
  logic             upd_carry;
  logic             carry_flag;

  logic [1:0]       grant;
  logic             prio;
  logic             accept;

  logic             sel;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [9:0]       sel_ctl;
  logic             sel_illegal;

  alu_rr_arbiter u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant),
    .prio   (prio)
  );

  assign req0_ready = (state == ST_IDLE) & grant[0];
  assign req1_ready = (state == ST_IDLE) & grant[1];
  assign accept     = req0_ready | req1_ready;

  assign sel         = grant[1];
  assign sel_op      = sel ? req1_op : req0_op;
  assign sel_a       = sel ? req1_a  : req0_a;
  assign sel_b       = sel ? req1_b  : req0_b;
  assign sel_ctl     = op2ctl(sel_op);
  assign sel_illegal = (sel_ctl == 10'b0);

  assign resp_valid = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      id_q       <= 1'b0;
      upd_carry  <= 1'b0;
      carry_flag <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctl    <= 10'b0;
      alu_cin    <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_z     <= 1'b0;
      resp_c     <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a     <= sel_a;
            alu_b     <= sel_b;
            alu_cin   <= (sel_op == OP_ADC) & carry_flag;
            id_q      <= sel;
            upd_carry <= op_sets_carry(sel_op);
            cnt       <= (sel_op == OP_MUL) ? CNT_MUL : '0;
            if (sel_illegal) begin
              // Nothing to execute: answer straight away with zeroed data/flags.
              alu_ctl   <= 10'b0;
              resp_id   <= sel;
              resp_data <= '0;
              resp_z    <= 1'b0;
              resp_c    <= 1'b0;
              resp_err  <= 1'b1;
              state     <= ST_RESP;
            end else begin
              alu_ctl <= sel_ctl;
              state   <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          if (cnt == '0) begin
            resp_id   <= id_q;
            resp_data <= alu_out;
            resp_z    <= alu_zout;
            resp_c    <= alu_cout;
            resp_err  <= 1'b0;
            alu_ctl   <= 10'b0;
            if (upd_carry) begin
              carry_flag <= alu_cout;
            end
            state <= ST_RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_RESP: begin
          if (resp_ready) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a transaction-level model

module tb_alu_sequencer;

  localparam int MULC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, resp_z, resp_c, resp_err;
  logic [15:0] resp_data;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [9:0]  alu_ctl;
  logic        alu_cin, alu_cout, alu_zout, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(16), .MUL_CYCLES(MULC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_z(resp_z), .resp_c(resp_c), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_zout(alu_zout),
    .busy(busy)
  );

  // Environment ALU: decodes the one-hot control word.
  logic [16:0] alu_r;
  always_comb begin
    alu_r = 17'd0;
    case (alu_ctl)
      10'b1000000000: alu_r = {1'b0, alu_b};
      10'b0100000000: alu_r = {1'b0, alu_a & alu_b};
      10'b0010000000: alu_r = {1'b0, alu_a | alu_b};
      10'b0001000000: alu_r = {1'b0, ~alu_b};
      10'b0000100000: alu_r = {1'b0, alu_b << 1};
      10'b0000010000: alu_r = {1'b0, alu_b >> 1};
      10'b0000001000: alu_r = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
      10'b0000000100: alu_r = {alu_a < alu_b, alu_a - alu_b};
      10'b0000000010: alu_r = {1'b0, alu_a * alu_b};
      10'b0000000001: alu_r = {alu_a < alu_b, alu_a - alu_b};
      default:        alu_r = 17'd0;
    endcase
  end
  assign alu_out  = alu_r[15:0];
  assign alu_cout = alu_r[16];
  assign alu_zout = (alu_r[15:0] == 16'd0);

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // Expected response of one opcode: {err, c, z, data}.
  function automatic logic [18:0] ref_op(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cf);
    logic [31:0] s;
    logic [15:0] d;
    logic        c, e;
    s = 32'd0; d = 16'd0; c = 1'b0; e = 1'b0;
    case (op)
      4'd0: d = b;
      4'd1: d = a & b;
      4'd2: d = a | b;
      4'd3: d = ~b;
      4'd4: d = b << 1;
      4'd5: d = b >> 1;
      4'd6: begin s = {16'd0, a} + {16'd0, b}; d = s[15:0]; c = s[16]; end
      4'd7, 4'd9: begin d = a - b; c = (a < b); end
      4'd8: begin s = {16'd0, a} * {16'd0, b}; d = s[15:0]; end
      4'd10: begin s = {16'd0, a} + {16'd0, b} + {31'd0, cf}; d = s[15:0]; c = s[16]; end
      default: e = 1'b1;
    endcase
    return {e, c, (!e && d == 16'd0), d};
  endfunction

  // Timeline model: an op accepted in cycle m_acc executes in cycles
  // m_acc+1..m_acc+m_n and is offered from cycle m_acc+m_n+1 until taken.
  bit          mon_en = 1'b0;
  int          mcyc = 0;
  bit          m_busy = 1'b0, m_prio = 1'b0, m_cf = 1'b0;
  int          m_acc = 0, m_n = 0;
  logic        m_id, m_cin, m_z, m_c, m_err;
  logic [3:0]  m_op;
  logic [15:0] m_a, m_b, m_data;
  logic [9:0]  m_ctl;
  logic [18:0] m_r;
  logic        e_r0, e_r1, in_exec, in_resp;

  always @(negedge clk) begin
    if (mon_en) begin
      mcyc = mcyc + 1;
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin
          e_r0 = !m_prio;
          e_r1 = m_prio;
        end else begin
          e_r0 = req0_valid;
          e_r1 = req1_valid;
        end
      end
      in_exec = m_busy && (mcyc > m_acc) && (mcyc <= m_acc + m_n);
      in_resp = m_busy && (mcyc > m_acc + m_n);
      chk("m_req0_ready", req0_ready, e_r0);
      chk("m_req1_ready", req1_ready, e_r1);
      chk("m_busy", busy, m_busy);
      chk("m_resp_valid", resp_valid, in_resp);
      chk("m_alu_ctl", alu_ctl, in_exec ? m_ctl : 10'd0);
      if (in_exec) begin
        chk("m_alu_a", alu_a, m_a);
        chk("m_alu_b", alu_b, m_b);
        chk("m_alu_cin", alu_cin, m_cin);
      end
      if (in_resp) begin
        chk("m_resp_id", resp_id, m_id);
        chk("m_resp_data", resp_data, m_data);
        chk("m_resp_z", resp_z, m_z);
        chk("m_resp_c", resp_c, m_c);
        chk("m_resp_err", resp_err, m_err);
      end
      if (rst) begin
        m_busy = 1'b0;
        m_prio = 1'b0;
        m_cf   = 1'b0;
      end else if (e_r0 || e_r1) begin
        m_busy = 1'b1;
        m_acc  = mcyc;
        m_id   = e_r1;
        m_op   = e_r1 ? req1_op : req0_op;
        m_a    = e_r1 ? req1_a : req0_a;
        m_b    = e_r1 ? req1_b : req0_b;
        m_r    = ref_op(m_op, m_a, m_b, m_cf);
        m_err  = m_r[18];
        m_c    = m_r[17];
        m_z    = m_r[16];
        m_data = m_r[15:0];
        m_cin  = (m_op == 4'd10) ? m_cf : 1'b0;
        m_n    = m_err ? 0 : ((m_op == 4'd8) ? MULC : 1);
        m_ctl  = (m_op == 4'd10) ? 10'b0000001000 : (10'b1000000000 >> m_op);
        if (m_op == 4'd6 || m_op == 4'd7 || m_op == 4'd9 || m_op == 4'd10) m_cf = m_c;
        m_prio = !e_r1;
      end else if (in_resp && resp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // Results of the most recent issue() call.
  logic [15:0] r_data;
  logic        r_z, r_c, r_err, r_id, x_cin;
  logic [9:0]  x_ctl;
  int          r_lat, x_held;

  task automatic issue(input logic id, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    int   t;
    logic got, seen;
    if (id) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    t = 0;
    got = 1'b0;
    while (!got && t < 50) begin
      @(negedge clk);
      t++;
      got = id ? req1_ready : req0_ready;
    end
    chk("accept_seen", got, 1);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    r_lat = 0; x_held = 0; x_ctl = 10'd0; x_cin = 1'b0; seen = 1'b0;
    while (!seen && r_lat < 50) begin
      @(negedge clk);
      r_lat++;
      if (r_lat == 1) begin x_ctl = alu_ctl; x_cin = alu_cin; end
      if (resp_valid) seen = 1'b1;
      else if (alu_ctl != 10'd0) x_held++;
    end
    chk("resp_seen", seen, 1);
    r_data = resp_data; r_z = resp_z; r_c = resp_c; r_err = resp_err; r_id = resp_id;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || resp_valid) && t < 60);
    chk("idle_reached", busy, 0);
    @(posedge clk); #1;
  endtask

  logic g [4];
  int   got_n, tt, rv_seen;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 4'd0; req1_op = 4'd0;
    req0_a = 16'd0; req0_b = 16'd0; req1_a = 16'd0; req1_b = 16'd0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_alu_ctl", alu_ctl, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_resp_data", resp_data, 0);
    @(posedge clk); #1;

    // 1: ADD on requester 0
    issue(1'b0, 4'd6, 16'h000D, 16'h000D);
    chk("t1_data", r_data, 16'h001A);
    chk("t1_z", r_z, 0);
    chk("t1_c", r_c, 0);
    chk("t1_id", r_id, 0);
    chk("t1_lat", r_lat, 2);

    // 2: SUB, SHL, NOTB on requester 1
    issue(1'b1, 4'd7, 16'h000D, 16'h000D);
    chk("t2_sub_data", r_data, 16'h0000);
    chk("t2_sub_z", r_z, 1);
    chk("t2_sub_id", r_id, 1);
    issue(1'b1, 4'd4, 16'h0000, 16'h000D);
    chk("t2_shl_data", r_data, 16'h001A);
    issue(1'b1, 4'd3, 16'h0000, 16'h000D);
    chk("t2_notb_data", r_data, 16'hFFF2);
    chk("t2_notb_z", r_z, 0);

    // 3: both requesters valid every cycle
    req0_op = 4'd6; req0_a = 16'h0001; req0_b = 16'h0002;
    req1_op = 4'd2; req1_a = 16'h0004; req1_b = 16'h0008;
    req0_valid = 1'b1; req1_valid = 1'b1;
    got_n = 0; tt = 0;
    while (got_n < 4 && tt < 200) begin
      @(negedge clk);
      tt++;
      if (req0_ready || req1_ready) begin
        g[got_n] = req1_ready;
        got_n++;
      end
    end
    chk("t3_grants", got_n, 4);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3_g0", g[0], 0);
    chk("t3_g1", g[1], 1);
    chk("t3_g2", g[2], 0);
    chk("t3_g3", g[3], 1);
    wait_idle();

    // 4: MUL held for MUL_CYCLES
    issue(1'b0, 4'd8, 16'h0003, 16'h0005);
    chk("t4_ctl", x_ctl, 10'b0000000010);
    chk("t4_held", x_held, 3);
    chk("t4_lat", r_lat, 4);
    chk("t4_data", r_data, 16'h000F);

    // 5: carry out of ADD feeds ADC
    issue(1'b0, 4'd6, 16'hFFFF, 16'h0001);
    chk("t5_add_data", r_data, 16'h0000);
    chk("t5_add_c", r_c, 1);
    issue(1'b1, 4'd10, 16'h0001, 16'h0001);
    chk("t5_adc_cin", x_cin, 1);
    chk("t5_adc_data", r_data, 16'h0003);

    // 6a: response back-pressure with a competing request
    resp_ready = 1'b0;
    issue(1'b0, 4'd6, 16'h0005, 16'h0006);
    chk("t6_first", r_data, 16'h000B);
    req1_op = 4'd1; req1_a = 16'hF0F0; req1_b = 16'h0FF0; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_hold_valid", resp_valid, 1);
      chk("t6_hold_data", resp_data, 16'h000B);
      chk("t6_hold_id", resp_id, 0);
      chk("t6_no_ready", {req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    tt = 0;
    do begin
      @(negedge clk);
      tt++;
    end while (!req1_ready && tt < 20);
    chk("t6_req1_taken", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_idle();

    // 6b: illegal opcode
    issue(1'b1, 4'd12, 16'h1234, 16'h5678);
    chk("t6_err", r_err, 1);
    chk("t6_err_data", r_data, 16'h0000);
    chk("t6_err_zc", {r_z, r_c}, 0);
    chk("t6_err_id", r_id, 1);
    chk("t6_err_lat", r_lat, 1);
    chk("t6_err_ctl", x_ctl, 0);

    // 6c: reset in the middle of MUL execution (carry flag is 1 beforehand)
    issue(1'b0, 4'd6, 16'h8000, 16'h8000);
    chk("t6_pre_c", r_c, 1);
    req0_op = 4'd8; req0_a = 16'h0007; req0_b = 16'h0009; req0_valid = 1'b1;
    tt = 0;
    do begin
      @(negedge clk);
      tt++;
    end while (!req0_ready && tt < 20);
    chk("t6_mul_taken", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", resp_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ctl", alu_ctl, 0);
    chk("t6_rst_ab", {alu_a, alu_b}, 0);
    chk("t6_rst_cin", alu_cin, 0);
    chk("t6_rst_resp", {resp_id, resp_data, resp_z, resp_c, resp_err}, 0);
    rv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
    end
    chk("t6_no_resp", rv_seen, 0);
    @(posedge clk); #1;
    issue(1'b0, 4'd10, 16'h0001, 16'h0001);
    chk("t6_cf_cleared_cin", x_cin, 0);
    chk("t6_cf_cleared_data", r_data, 16'h0002);

    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
